led_step_sequencer: RTL

Parametrised LED step sequencer that drives a bank of N_LED indicator LEDs through a selectable pattern at a programmable step rate. It supersedes the fixed 4-LED rotator. The step clock is a single-cycle enable from an internal prescaler, so all logic runs in the FPGA_CLK domain with no derived clock. The block adds run/pause, manual single-step and four runtime-selectable patterns. It sits directly behind the board-level LED pins; mode, run and step controls come from already-synchronised, debounced board inputs or a host register.

---
 rtl/led_step_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/led_step_sequencer.sv
// led_step_sequencer
// Steps a bank of N_LED indicator LEDs through one of four patterns at a
// programmable rate. The step rate comes from an internal prescaler that
// produces a single-cycle advance enable, so everything runs on FPGA_CLK.
//
// Ports
//   FPGA_CLK    system clock, rising edge
//   FPGA_RST_N  asynchronous active-low reset
//   mode[1:0]   pattern select: 00 rotate-up, 01 rotate-down, 10 bounce, 11 fill
//   run         1 = prescaler counts and auto-steps, 0 = paused
//   step_req    manual advance pulse, honoured only while run=0
//   F_LED       registered LED drive, active-high, bit 0 = LED1
//   step_tick   registered pulse, high the cycle after each pattern advance
//
// Bounce direction register:
//   state    | meaning
//   DIR_UP   | bounce lit LED moving toward the MSB
//   DIR_DOWN | bounce lit LED moving toward bit 0
module led_step_sequencer #(
   parameter int N_LED       = 4,
   parameter int STEP_CYCLES = 25_000_000
) (
   input  logic             FPGA_CLK,
   input  logic             FPGA_RST_N,
   input  logic [1:0]       mode,
   input  logic             run,
   input  logic             step_req,
   output logic [N_LED-1:0] F_LED,
   output logic             step_tick
);

   localparam int PW = $clog2(STEP_CYCLES);
   localparam logic [PW-1:0]    PRESC_MAX = PW'(STEP_CYCLES - 1);
   localparam logic [N_LED-1:0] LED_FIRST = N_LED'(1);
   localparam logic [N_LED-1:0] LED_ALL   = '1;

   localparam logic [1:0] MODE_ROT_UP   = 2'b00;
   localparam logic [1:0] MODE_ROT_DOWN = 2'b01;
   localparam logic [1:0] MODE_BOUNCE   = 2'b10;
   localparam logic [1:0] MODE_FILL     = 2'b11;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   dir_t             dir_q, dir_d, dir_nx;
   logic [1:0]       mode_q;
   logic [PW-1:0]    presc_q, presc_d;
   logic [N_LED-1:0] led_d, led_nx;
   logic             tick_d;
   logic             mode_chg;
   logic             term_cnt;
   logic             advance;

   always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
      if (!FPGA_RST_N) begin
         F_LED     <= LED_FIRST;
         presc_q   <= '0;
         dir_q     <= DIR_UP;
         mode_q    <= MODE_ROT_UP;
         step_tick <= 1'b0;
      end else begin
         F_LED     <= led_d;
         presc_q   <= presc_d;
         dir_q     <= dir_d;
         mode_q    <= mode;
         step_tick <= tick_d;
      end
   end

   // Next pattern value for the currently latched mode.
   always_comb begin
      led_nx = F_LED;
      dir_nx = dir_q;
      case (mode_q)
         MODE_ROT_UP:   led_nx = {F_LED[N_LED-2:0], F_LED[N_LED-1]};
         MODE_ROT_DOWN: led_nx = {F_LED[0], F_LED[N_LED-1:1]};
         MODE_BOUNCE: begin
            // Direction flips on the step that lands on an end LED, so the
            // end LEDs stay lit for exactly one step.
            if (dir_q == DIR_UP) begin
               led_nx = F_LED << 1;
               if (led_nx[N_LED-1]) dir_nx = DIR_DOWN;
            end else begin
               led_nx = F_LED >> 1;
               if (led_nx[0]) dir_nx = DIR_UP;
            end
         end
         MODE_FILL: begin
            if (F_LED == LED_ALL) led_nx = '0;
            else                  led_nx = {F_LED[N_LED-2:0], 1'b1};
         end
         default: led_nx = F_LED;
      endcase
   end

   always_comb begin
      mode_chg = (mode != mode_q);
      term_cnt = run && (presc_q == PRESC_MAX);
      advance  = term_cnt || (!run && step_req);

      presc_d = presc_q;
      led_d   = F_LED;
      dir_d   = dir_q;
      tick_d  = 1'b0;

      if (mode_chg) begin
         // Restart the new pattern cleanly; a coincident advance is dropped.
         presc_d = '0;
         led_d   = LED_FIRST;
         dir_d   = DIR_UP;
      end else begin
         if (run) presc_d = term_cnt ? '0 : presc_q + PW'(1);
         if (advance) begin
            led_d  = led_nx;
            dir_d  = dir_nx;
            tick_d = 1'b1;
         end
      end
   end

endmodule
